alu_serial_nbit: RTL and testbench

ALU_SERIAL_NBIT -- requirements
Module: alu_serial_nbit

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_digit_slice.sv | 42 ++++
 rtl/alu_serial_nbit.sv | 162 ++++++++++++++++
 tb/tb_alu_serial_nbit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared types and constants for the digit-serial ALU.
//   op_e      : opcode encoding (101-111 are illegal)
//   state_e   : control FSM states
//   FLAG_*    : bit positions inside the 4-bit {N, Z, C, V} flags bus
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_digit_slice.sv
// alu_digit_slice -- one SLICE_W-bit combinational ALU digit.
//   a, b  : digit operands (b arrives already inverted for subtraction)
//   cin   : carry into this digit
//   op    : opcode; ADD and SUB both use the adder path
//   y     : digit result (zero for illegal opcodes)
//   cout  : carry out of this digit (zero for non-arithmetic opcodes)
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic [2:0]         op,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  logic [SLICE_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_ADD, OP_SUB: begin
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      default: begin
        y    = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_nbit.sv
// alu_serial_nbit -- digit-serial ALU, SLICE_W bits per clock, LSB first.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (A_i, B_i, op)
//   out_valid/out_ready : result handshake (Result, flags {N,Z,C,V}, err)
// A bundle accepted on one edge produces out_valid exactly WIDTH/SLICE_W
// cycles later. Outputs are held until the consumer takes them.
// Optional build macro: ALU_SAT_EN -- saturate ADD/SUB results on signed
// overflow instead of wrapping.
module alu_serial_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int NDIG  = WIDTH / SLICE_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((SLICE_W > WIDTH) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_params
      $error("alu_serial_nbit: WIDTH must be a positive multiple of SLICE_W");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;       // shifts right one digit per BUSY cycle
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;   // digits enter at the top, shift down
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic [SLICE_W-1:0] dig_a, dig_b, dig_y;
  logic               dig_cout;
  logic               is_sub, is_arith, is_illegal;

  assign is_sub     = (op_q == OP_SUB);
  assign is_arith   = (op_q == OP_ADD) || is_sub;
  assign is_illegal = (op_q > OP_XOR);
  assign dig_a      = a_q[SLICE_W-1:0];
  assign dig_b      = is_sub ? ~b_q[SLICE_W-1:0] : b_q[SLICE_W-1:0];

  alu_digit_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .op   (op_q),
    .y    (dig_y),
    .cout (dig_cout)
  );

  logic [WIDTH-1:0] res_wrap, res_fin;
  logic             v_bit;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;

    res_wrap = (res_q >> SLICE_W) | (WIDTH'(dig_y) << (WIDTH - SLICE_W));
    // On the last digit dig_a/dig_b hold the operand MSBs (B already inverted
    // for SUB), so overflow is "same operand signs, different result sign".
    v_bit    = is_arith && (dig_a[SLICE_W-1] == dig_b[SLICE_W-1]) &&
               (dig_y[SLICE_W-1] != dig_a[SLICE_W-1]);
    res_fin  = res_wrap;
`ifdef ALU_SAT_EN
    if (v_bit) begin
      // Negative operands overflowing means the true result was below min.
      res_fin = dig_a[SLICE_W-1] ? (WIDTH'(1) << (WIDTH - 1))
                                 : ~(WIDTH'(1) << (WIDTH - 1));
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A_i;
          b_d     = B_i;
          op_d    = op;
          carry_d = (op == OP_SUB);
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = dig_cout;
        res_d   = res_wrap;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          cnt_d           = '0;
          res_d           = res_fin;
          flags_d[FLAG_N] = res_fin[WIDTH-1];
          flags_d[FLAG_Z] = (res_fin == '0);
          flags_d[FLAG_C] = is_arith && dig_cout;
          flags_d[FLAG_V] = v_bit;
          err_d           = is_illegal;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Result    = res_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_serial_nbit.sv
// tb_alu_serial_nbit -- directed vectors for alu_serial_nbit (16-bit, 4-bit
// digits). Build with +define+ALU_SAT_EN to exercise the saturating variant.
module tb_alu_serial_nbit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A_i, B_i;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Result;
  logic [3:0]  flags;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_serial_nbit #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_i       (A_i),
    .B_i       (B_i),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .flags     (flags),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one bundle, time the result, compare it, optionally stall the
  // consumer for 10 cycles, then consume.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic [3:0] exp_flags,
                        input logic exp_err, input bit hold);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    op = o; A_i = a; B_i = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_result"}, 32'(Result), 32'(exp_res));
    check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (hold) begin
      // A competing bundle is offered while the result waits; it must be ignored.
      in_valid = 1'b1; op = 3'b010; A_i = 16'h1111; B_i = 16'h2222;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_hold_result"}, 32'(Result), 32'(exp_res));
        check({tag, "_hold_flags"}, 32'(flags), 32'(exp_flags));
        check({tag, "_hold_err"}, 32'(err), 32'(exp_err));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    $display("txn %s: op=%b A=%h B=%h -> Result=%h flags=%b err=%b lat=%0d",
             tag, o, a, b, exp_res, exp_flags, exp_err, lat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A_i = '0; B_i = '0; op = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    run_op("add_basic", 3'b010, 16'h1234, 16'h0FCD, 16'h2201, 4'b0000, 1'b0, 1'b0);
`ifdef ALU_SAT_EN
    run_op("sub_ovf",   3'b011, 16'h8000, 16'h0001, 16'h8000, 4'b1011, 1'b0, 1'b0);
    run_op("add_ovf",   3'b010, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0001, 1'b0, 1'b0);
`else
    run_op("sub_ovf",   3'b011, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0, 1'b0);
    run_op("add_ovf",   3'b010, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0, 1'b0);
`endif
    run_op("add_wrap",  3'b010, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0, 1'b0);
    run_op("xor_zero",  3'b100, 16'hA5A5, 16'hA5A5, 16'h0000, 4'b0100, 1'b0, 1'b0);
    run_op("or_basic",  3'b001, 16'h1200, 16'h0034, 16'h1234, 4'b0000, 1'b0, 1'b0);
    run_op("sub_borrow",3'b011, 16'h0005, 16'h0007, 16'hFFFE, 4'b1000, 1'b0, 1'b0);
    run_op("illegal",   3'b111, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b1, 1'b1);

    // Abort an ADD while its third digit is being computed.
    op = 3'b010; A_i = 16'h1234; B_i = 16'h0FCD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(Result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);
    end
    $display("txn abort: ADD aborted by reset during digit 2");

    run_op("and_after", 3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
